// File: rtl/bin_to_xs3_seq.sv
// Sequential binary-to-decimal converter (double dabble, one bit per clock).
// Produces packed BCD or excess-3 digits, with start/busy/done handshake and overflow.
module bin_to_xs3_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      din,
   input  logic                  mode,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   dout,
   output logic                  ovf
);

   localparam int BW = 4*DIGITS;
   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  bin, bin_n;
   logic [BW-1:0]     bcd, bcd_n, adj, xs3, dout_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              mode_q, mode_q_n, sticky, sticky_n;
   logic              busy_n, done_n, ovf_n, carry;
   logic [BW+WIDTH:0] cat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         bin    <= '0;
         bcd    <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
         sticky <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         dout   <= '0;
         ovf    <= 1'b0;
      end else begin
         state  <= state_n;
         bin    <= bin_n;
         bcd    <= bcd_n;
         cnt    <= cnt_n;
         mode_q <= mode_q_n;
         sticky <= sticky_n;
         busy   <= busy_n;
         done   <= done_n;
         dout   <= dout_n;
         ovf    <= ovf_n;
      end
   end

   always_comb begin
      adj = '0;
      xs3 = '0;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      // Extra low zero keeps the shift well-formed even when WIDTH is 1.
      cat   = {adj, bin, 1'b0};
      carry = cat[BW+WIDTH];
      for (int i = 0; i < DIGITS; i++)
         xs3[4*i +: 4] = cat[WIDTH+4*i +: 4] + 4'd3;

      state_n  = state;
      bin_n    = bin;
      bcd_n    = bcd;
      cnt_n    = cnt;
      mode_q_n = mode_q;
      sticky_n = sticky;
      busy_n   = busy;
      done_n   = 1'b0;
      dout_n   = dout;
      ovf_n    = ovf;

      case (state)
         IDLE: begin
            if (start) begin
               bin_n    = din;
               bcd_n    = '0;
               mode_q_n = mode;
               sticky_n = 1'b0;
               cnt_n    = CW'(WIDTH);
               busy_n   = 1'b1;
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            bin_n    = cat[WIDTH-1:0];
            bcd_n    = cat[BW+WIDTH-1:WIDTH];
            sticky_n = sticky | carry;
            cnt_n    = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               dout_n  = mode_q ? xs3 : cat[BW+WIDTH-1:WIDTH];
               ovf_n   = sticky | carry;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
